// File: rtl/output_queue_if.sv
// Shared state type and the handshake bundle between the cipher datapath and the output queue.
// master = encryption block / interface FSM side, slave = the queue itself.
package output_queue_pkg;
    typedef enum logic {
        O_EMPTY = 1'b0,
        O_READY = 1'b1
    } output_holder_state_t;
endpackage

interface output_queue_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0]                   data_in;
    logic                                data_in_pulse;
    logic                                read_ack;
    logic                                flush;
    output_queue_pkg::output_holder_state_t output_holder_state_out;
    logic [DATA_W-1:0]                   data_out;
    logic [CNT_W-1:0]                    count;
    logic                                full;
    logic                                overflow;

    modport master (
        output data_in, data_in_pulse, read_ack, flush,
        input  output_holder_state_out, data_out, count, full, overflow
    );

    modport slave (
        input  data_in, data_in_pulse, read_ack, flush,
        output output_holder_state_out, data_out, count, full, overflow
    );
endinterface

// File: rtl/output_queue.sv
// DEPTH-entry FIFO capturing single-cycle ciphertext pulses and holding the head word until read_ack.
// Latency: a pulse or ack at edge N is reflected on the outputs after edge N; outputs are purely registered.
// Backpressure: none upstream; a pulse into a full queue without a same-cycle ack is dropped and sets sticky overflow.
module output_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              nrst,
    output_queue_if.slave     q
);
    import output_queue_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              ovf_q,    ovf_d;

    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;
    logic              is_full, is_empty, push, pop;

    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == '0);
    assign pop      = q.read_ack && !is_empty;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign push     = q.data_in_pulse && (!is_full || pop);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q;
        if (q.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            if (q.data_in_pulse) begin
                mem_we    = 1'b1;
                mem_waddr = '0;
                wr_ptr_d  = PTR_W'(1);
                count_d   = CNT_W'(1);
            end
        end else begin
            if (push) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (q.data_in_pulse && !push) begin
                ovf_d = 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is intentionally unreset; stale words are hidden by the empty mask below.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= q.data_in;
        end
    end

    assign q.data_out                = is_empty ? '0 : mem_q[rd_ptr_q];
    assign q.count                   = count_q;
    assign q.full                    = is_full;
    assign q.overflow                = ovf_q;
    assign q.output_holder_state_out = is_empty ? O_EMPTY : O_READY;
endmodule

// File: tb/tb_output_queue.sv
// Bench for output_queue: hand-derived vector table for the directed scenarios,
// then random traffic against a queue-based reference model, then an asynchronous reset mid-stream.
module tb_output_queue;
    import output_queue_pkg::*;

    localparam int DW = 8;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    output_queue_if #(.DATA_W(DW), .DEPTH(DP)) qif ();
    output_queue #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk  (clk),
        .nrst (nrst),
        .q    (qif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mq [$];
    bit            m_ovf;

    typedef struct {
        bit            p;
        logic [DW-1:0] d;
        bit            a;
        bit            f;
        int            c;
        logic [DW-1:0] dout;
        bit            full;
        bit            ovf;
    } vec_t;

    vec_t tbl [$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int c, input logic [DW-1:0] d,
                             input bit f, input bit o);
        cmp({tag, " count"},    32'(qif.count), 32'(c));
        cmp({tag, " data_out"}, 32'(qif.data_out), 32'(d));
        cmp({tag, " full"},     32'(qif.full), 32'(f));
        cmp({tag, " overflow"}, 32'(qif.overflow), 32'(o));
        cmp({tag, " state"},    32'(qif.output_holder_state_out), (c != 0) ? 32'(O_READY) : 32'(O_EMPTY));
    endtask

    task automatic check_model(input string tag);
        check_all(tag, mq.size(), (mq.size() != 0) ? mq[0] : '0, mq.size() == DP, m_ovf);
    endtask

    function automatic void model_step(input bit p, input logic [DW-1:0] d, input bit a, input bit f);
        bit was_full;
        if (f) begin
            mq.delete();
            m_ovf = 1'b0;
            if (p) mq.push_back(d);
        end else begin
            was_full = (mq.size() == DP);
            if (a && mq.size() != 0) begin
                void'(mq.pop_front());
                was_full = 1'b0;
            end
            if (p) begin
                if (was_full) m_ovf = 1'b1;
                else          mq.push_back(d);
            end
        end
    endfunction

    task automatic drive(input bit p, input logic [DW-1:0] d, input bit a, input bit f);
        @(negedge clk);
        qif.data_in_pulse = p;
        qif.data_in       = d;
        qif.read_ack      = a;
        qif.flush         = f;
        @(posedge clk);
        model_step(p, d, a, f);
        #1;
        qif.data_in_pulse = 1'b0;
        qif.read_ack      = 1'b0;
        qif.flush         = 1'b0;
    endtask

    initial begin
        int k;
        logic [DW-1:0] rd;

        qif.data_in       = '0;
        qif.data_in_pulse = 1'b0;
        qif.read_ack      = 1'b0;
        qif.flush         = 1'b0;
        nrst              = 1'b0;
        m_ovf             = 1'b0;
        #1;
        check_all("reset", 0, 8'h00, 0, 0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;

        // p, d, a, f, count, data_out, full, overflow
        tbl.push_back('{1, 8'h11, 0, 0, 1, 8'h11, 0, 0});
        tbl.push_back('{1, 8'h22, 0, 0, 2, 8'h11, 0, 0});
        tbl.push_back('{1, 8'h33, 0, 0, 3, 8'h11, 0, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 2, 8'h22, 0, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 1, 8'h33, 0, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 0, 0});
        // fill then overflow
        tbl.push_back('{1, 8'hA0, 0, 0, 1, 8'hA0, 0, 0});
        tbl.push_back('{1, 8'hA1, 0, 0, 2, 8'hA0, 0, 0});
        tbl.push_back('{1, 8'hA2, 0, 0, 3, 8'hA0, 0, 0});
        tbl.push_back('{1, 8'hA3, 0, 0, 4, 8'hA0, 1, 0});
        tbl.push_back('{1, 8'hFF, 0, 0, 4, 8'hA0, 1, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 3, 8'hA1, 0, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 2, 8'hA2, 0, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 1, 8'hA3, 0, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 0, 1});
        tbl.push_back('{0, 8'h00, 0, 1, 0, 8'h00, 0, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 0, 0});
        // push and pop together while full
        tbl.push_back('{1, 8'hA0, 0, 0, 1, 8'hA0, 0, 0});
        tbl.push_back('{1, 8'hA1, 0, 0, 2, 8'hA0, 0, 0});
        tbl.push_back('{1, 8'hA2, 0, 0, 3, 8'hA0, 0, 0});
        tbl.push_back('{1, 8'hA3, 0, 0, 4, 8'hA0, 1, 0});
        tbl.push_back('{1, 8'h5A, 1, 0, 4, 8'hA1, 1, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 3, 8'hA2, 0, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 2, 8'hA3, 0, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 1, 8'h5A, 0, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 0, 0});
        // empty queue: pulse+ack is a push, lone ack is ignored
        tbl.push_back('{1, 8'h77, 1, 0, 1, 8'h77, 0, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 0, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 0, 0});
        // overflow with two held words, then flush with pulse
        tbl.push_back('{1, 8'h01, 0, 0, 1, 8'h01, 0, 0});
        tbl.push_back('{1, 8'h02, 0, 0, 2, 8'h01, 0, 0});
        tbl.push_back('{1, 8'h03, 0, 0, 3, 8'h01, 0, 0});
        tbl.push_back('{1, 8'h04, 0, 0, 4, 8'h01, 1, 0});
        tbl.push_back('{1, 8'h05, 0, 0, 4, 8'h01, 1, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 3, 8'h02, 0, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 2, 8'h03, 0, 1});
        tbl.push_back('{1, 8'h3C, 0, 1, 1, 8'h3C, 0, 0});
        tbl.push_back('{0, 8'h00, 0, 1, 0, 8'h00, 0, 0});
        tbl.push_back('{1, 8'h3D, 1, 1, 1, 8'h3D, 0, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 0, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].p, tbl[i].d, tbl[i].a, tbl[i].f);
            check_all($sformatf("vec%0d", i), tbl[i].c, tbl[i].dout, tbl[i].full, tbl[i].ovf);
        end

        // Random traffic against the reference model, starting from a known empty state.
        drive(0, '0, 0, 1);
        mq.delete();
        m_ovf = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom % 2), DW'($urandom), 1'($urandom % 2), ($urandom % 25) == 0);
            check_model($sformatf("rnd%0d", i));
        end

        // Wrap-around: paired push/pop at occupancy 1..3.
        drive(0, '0, 0, 1);
        k = $urandom_range(1, 3);
        for (int i = 0; i < k; i++) begin
            drive(1, DW'($urandom), 0, 0);
        end
        for (int i = 0; i < 10; i++) begin
            rd = DW'($urandom);
            drive(1, rd, 1, 0);
            check_model($sformatf("wrap%0d", i));
            if ($urandom % 3 == 0 && mq.size() > 1) begin
                drive(0, '0, 1, 0);
                check_model($sformatf("wrap_pop%0d", i));
            end else if ($urandom % 3 == 0 && mq.size() < 3) begin
                drive(1, DW'($urandom), 0, 0);
                check_model($sformatf("wrap_push%0d", i));
            end
        end

        // Asynchronous reset mid-stream must clear the outputs before any clock edge.
        @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check_all("async_rst", 0, 8'h00, 0, 0);
        mq.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        drive(1, 8'h99, 0, 0);
        check_model("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/output_queue.md
# output_queue

Parametrised multi-entry output holder for the stream cipher datapath. It sits between the encryption block and the output mux and captures each single-cycle ciphertext pulse into a DEPTH-entry FIFO. Each word is held at the output until the interface FSM acknowledges that it has been read. It reports queue status to the interface FSM, including a sticky overflow flag, and supports a flush when the interface returns to idle.

## Interface

Parameters:
- DATA_W, default 8: width of each held word.
- DEPTH, default 4: number of entries. Must be a power of two and at least 2.
- CNT_W, default $clog2(DEPTH+1): width of the occupancy count. Derived; not overridden.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- nrst, input, 1: asynchronous, active-low reset.
- data_in, input, DATA_W: word from the encryption block.
- data_in_pulse, input, 1: single-cycle strobe; data_in is valid this cycle.
- read_ack, input, 1: single-cycle strobe from the interface FSM; the current head word has been consumed.
- flush, input, 1: level from the interface FSM; high while the interface is in idle.
- output_holder_state_out, output, output_holder_state_t: O_EMPTY when count==0, O_READY otherwise.
- data_out, output, DATA_W: head word to the output mux; all zeros when empty.
- count, output, CNT_W: current occupancy, 0..DEPTH.
- full, output, 1: high when count==DEPTH.
- overflow, output, 1: sticky flag; a pulse arrived while the queue was full and was dropped.

## Operation

Storage:
- Circular buffer mem[DEPTH] with wr_ptr and rd_ptr, each $clog2(DEPTH) bits wide.
- Pointers wrap naturally from DEPTH-1 to 0.
- The count register is authoritative for empty/full; pointer equality is never used to decide them.
- mem contents are not reset; data_out is masked to zero whenever count==0.

Per-cycle actions, evaluated in priority order:
- flush=1:
  - rd_ptr, wr_ptr and overflow are cleared; count becomes 0.
  - If data_in_pulse is also high, data_in is written to mem[0], wr_ptr becomes 1 and count becomes 1.
  - read_ack is ignored.
- push: data_in_pulse=1 and (count<DEPTH, or read_ack=1 with count>0).
  - mem[wr_ptr] is loaded with data_in and wr_ptr increments.
- drop: data_in_pulse=1, count==DEPTH and read_ack=0.
  - The word is discarded; overflow is set to 1.
  - No pointer or count change.
- pop: read_ack=1 and count>0.
  - rd_ptr increments.
  - read_ack with count==0 is ignored.
- Count update: push and pop in the same cycle leaves count unchanged; push alone adds 1; pop alone subtracts 1.
- Simultaneous push and pop is legal at any occupancy from 1 to DEPTH, including full.
- At count==0, a simultaneous pulse and ack results in a push only (count becomes 1).

Output and status derivation:
- data_out = (count!=0) ? mem[rd_ptr] : '0. Combinational from registers, so there is no logic path from any input to any output.
- full and output_holder_state_out are decoded combinationally from count.
- overflow is cleared only by reset or flush.

## Timing

Reset (nrst low, asynchronous):
- count=0, pointers=0, overflow=0.
- data_out=0, full=0, output_holder_state_out=O_EMPTY.
- Reset asserted mid-operation discards all held words immediately, without waiting for a clock edge.

Latency and handshake:
- Write latency is 1 cycle: a pulse at edge N is visible on data_out, count and status after edge N.
- After a read_ack at edge N, the next head word (or zero) appears after edge N.
- read_ack must be a single-cycle strobe. Holding it high for k cycles pops min(k, count) words.
- data_in_pulse has the same single-cycle contract: k high cycles represent k separate words.
- A flush held high for multiple cycles keeps the queue empty. The exception is the final flush cycle, which may coincide with a pulse and store that word.

## Test plan

- Reset, then 3 pulses with data_in=0x11, 0x22, 0x33 (DEPTH=4) -> count=3, data_out=0x11, state O_READY. Three read_acks then yield 0x22, 0x33, 0, and state returns to O_EMPTY.
- Fill to DEPTH=4 with 0xA0..0xA3, then pulse 0xFF -> full=1, overflow=1, count=4. Draining yields 0xA0..0xA3 only; overflow stays 1 until flush.
- Full queue, same-cycle pulse 0x5A and read_ack -> count stays 4, overflow stays 0, head advances to 0xA1. After draining, 0x5A emerges last.
- Empty queue, same-cycle pulse 0x77 and read_ack -> count=1, data_out=0x77. A lone read_ack on an empty queue leaves all outputs at 0.
- Queue holding 2 words with overflow=1, then flush high together with pulse 0x3C -> count=1, data_out=0x3C, overflow=0.
- Wrap-around test:
  - Run 10 push/pop pairs at random occupancy 1..3 and check FIFO ordering against a reference model.
  - Assert nrst mid-stream -> all outputs are 0 and state is O_EMPTY before the next clock edge.
